// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and the function under test / controller.
// master is the checker side, slave is the stimulus/function side.
interface truth_table_checker_if #(
   parameter int N_IN = 3
);
   logic            start;
   logic [N_IN-1:0] dut_in;
   logic            dut_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic            fail_valid;
   logic [N_IN-1:0] first_fail;

   modport master (
      input  start, dut_out,
      output dut_in, busy, done, pass, err_count, fail_valid, first_fail
   );

   modport slave (
      output start, dut_out,
      input  dut_in, busy, done, pass, err_count, fail_valid, first_fail
   );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a small combinational function, holds each for
// SETTLE cycles, then compares the sampled output against the golden table.
module truth_table_checker #(
   parameter int                      N_IN     = 3,
   parameter logic [(1<<N_IN)-1:0]    EXPECTED = 8'hE2,
   parameter int                      SETTLE   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   truth_table_checker_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_e;

   localparam int              TW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [TW-1:0]   T_LAST = TW'(SETTLE - 1);
   localparam logic [N_IN-1:0] V_LAST = '1;

   state_e          state_q, state_d;
   logic [N_IN-1:0] vector_q, vector_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [N_IN:0]   err_count_q, err_count_d;
   logic            fail_valid_q, fail_valid_d;
   logic [N_IN-1:0] first_fail_q, first_fail_d;
   logic            pass_q, pass_d;
   logic            mismatch;

   assign mismatch = (bus.dut_out != EXPECTED[vector_q]);

   // state register and datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         vector_q     <= '0;
         timer_q      <= '0;
         err_count_q  <= '0;
         fail_valid_q <= 1'b0;
         first_fail_q <= '0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vector_q     <= vector_d;
         timer_q      <= timer_d;
         err_count_q  <= err_count_d;
         fail_valid_q <= fail_valid_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_SETTLE;
         S_SETTLE: if (timer_q == T_LAST) state_d = S_CHECK;
         S_CHECK:  state_d = (vector_q == V_LAST) ? S_DONE : S_SETTLE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      vector_d     = vector_q;
      timer_d      = timer_q;
      err_count_d  = err_count_q;
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               vector_d     = '0;
               timer_d      = '0;
               err_count_d  = '0;
               fail_valid_d = 1'b0;
               first_fail_d = '0;
               pass_d       = 1'b0;
            end
         end
         S_SETTLE: begin
            timer_d = (timer_q == T_LAST) ? '0 : timer_q + 1'b1;
         end
         S_CHECK: begin
            if (mismatch) begin
               err_count_d = err_count_q + 1'b1;
               if (!fail_valid_q) begin
                  first_fail_d = vector_q;
                  fail_valid_d = 1'b1;
               end
            end
            // pass must see a mismatch on the final vector too, hence err_count_d
            if (vector_q == V_LAST) pass_d = (err_count_d == '0);
            else                    vector_d = vector_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.busy = (state_q != S_IDLE);
      bus.done = (state_q == S_DONE);
   end

   assign bus.dut_in     = vector_q;
   assign bus.err_count  = err_count_q;
   assign bus.fail_valid = fail_valid_q;
   assign bus.first_fail = first_fail_q;
   assign bus.pass       = pass_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: golden, stuck-at-0 and inverted functions, SETTLE=1 variant,
// held start, ignored re-pulse and mid-run reset.
module tb_truth_table_checker;

   localparam logic [1:0] M_GOLD = 2'd0, M_STUCK0 = 2'd1, M_INV = 2'd2;

   logic       clk;
   logic       rst;
   logic [1:0] mode_a;
   int         n_total;
   int         n_fail;

   truth_table_checker_if #(.N_IN(3)) a_if ();
   truth_table_checker_if #(.N_IN(3)) b_if ();

   truth_table_checker #(.N_IN(3), .EXPECTED(8'hE2), .SETTLE(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.master)
   );

   truth_table_checker #(.N_IN(3), .EXPECTED(8'hE2), .SETTLE(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // s = (~y & z) | (x & y), index {x,y,z}
   function automatic logic gold(input logic [2:0] v);
      return (~v[1] & v[0]) | (v[2] & v[1]);
   endfunction

   always_comb begin
      case (mode_a)
         M_STUCK0: a_if.dut_out = 1'b0;
         M_INV:    a_if.dut_out = ~gold(a_if.dut_in);
         default:  a_if.dut_out = gold(a_if.dut_in);
      endcase
   end

   always_comb b_if.dut_out = gold(b_if.dut_in);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, 32'(a_if.busy), 0);
      chk({tag, "_done"}, 32'(a_if.done), 0);
      chk({tag, "_in"},   32'(a_if.dut_in), 0);
      chk({tag, "_pass"}, 32'(a_if.pass), 0);
      chk({tag, "_err"},  32'(a_if.err_count), 0);
      chk({tag, "_fv"},   32'(a_if.fail_valid), 0);
      chk({tag, "_ff"},   32'(a_if.first_fail), 0);
   endtask

   // One full run on dut_a starting from IDLE; tick j after the start edge shows vector j/3.
   task automatic run_a(input string tag, input int exp_err, input int exp_ff,
                        input int exp_fv, input int exp_pass, input bit repulse);
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      chk({tag, "_busy0"}, 32'(a_if.busy), 1);
      chk({tag, "_in0"},   32'(a_if.dut_in), 0);
      chk({tag, "_pclr"},  32'(a_if.pass), 0);
      for (int j = 1; j < 24; j++) begin
         a_if.start = (repulse && j == 10);
         tick();
         chk({tag, "_vec"},    32'(a_if.dut_in), 32'(j / 3));
         chk({tag, "_nodone"}, 32'(a_if.done), 0);
         chk({tag, "_busy"},   32'(a_if.busy), 1);
      end
      a_if.start = 1'b0;
      tick();
      chk({tag, "_done"}, 32'(a_if.done), 1);
      chk({tag, "_dbusy"}, 32'(a_if.busy), 1);
      chk({tag, "_err"},  32'(a_if.err_count), 32'(exp_err));
      chk({tag, "_ff"},   32'(a_if.first_fail), 32'(exp_ff));
      chk({tag, "_fv"},   32'(a_if.fail_valid), 32'(exp_fv));
      chk({tag, "_pass"}, 32'(a_if.pass), 32'(exp_pass));
      chk({tag, "_din7"}, 32'(a_if.dut_in), 7);
      tick();
      chk({tag, "_done1"}, 32'(a_if.done), 0);
      chk({tag, "_idle"},  32'(a_if.busy), 0);
      chk({tag, "_hold"},  32'(a_if.dut_in), 7);
      chk({tag, "_phold"}, 32'(a_if.pass), 32'(exp_pass));
   endtask

   initial begin
      n_total    = 0;
      n_fail     = 0;
      mode_a     = M_GOLD;
      rst        = 1'b1;
      a_if.start = 1'b1;
      b_if.start = 1'b1;

      // reset with start held high: no run may begin
      repeat (3) tick();
      chk_idle_zero("rst");
      chk("rst_b_busy", 32'(b_if.busy), 0);
      rst        = 1'b0;
      a_if.start = 1'b0;
      b_if.start = 1'b0;
      tick();
      chk("post_rst_busy", 32'(a_if.busy), 0);
      chk("post_rst_b_busy", 32'(b_if.busy), 0);

      mode_a = M_GOLD;
      run_a("gold", 0, 0, 0, 1, 1'b0);

      mode_a = M_STUCK0;
      run_a("stuck0", 4, 1, 1, 0, 1'b0);

      mode_a = M_INV;
      run_a("inv", 8, 0, 1, 0, 1'b0);

      // start re-pulse mid-run must not disturb the sweep
      mode_a = M_GOLD;
      run_a("repulse", 0, 0, 0, 1, 1'b1);

      // SETTLE=1: done exactly 16 edges after start
      b_if.start = 1'b1;
      tick();
      b_if.start = 1'b0;
      chk("s1_busy", 32'(b_if.busy), 1);
      for (int j = 1; j < 16; j++) begin
         tick();
         chk("s1_vec", 32'(b_if.dut_in), 32'(j / 2));
         chk("s1_nodone", 32'(b_if.done), 0);
      end
      tick();
      chk("s1_done", 32'(b_if.done), 1);
      chk("s1_pass", 32'(b_if.pass), 1);
      chk("s1_err", 32'(b_if.err_count), 0);
      tick();
      chk("s1_done1", 32'(b_if.done), 0);

      // start held high: failing run, one idle cycle, then cleared restart
      mode_a     = M_STUCK0;
      a_if.start = 1'b1;
      tick();
      chk("held_busy0", 32'(a_if.busy), 1);
      repeat (24) tick();
      chk("held_done", 32'(a_if.done), 1);
      chk("held_err", 32'(a_if.err_count), 4);
      mode_a = M_GOLD;
      tick();
      chk("held_gap", 32'(a_if.busy), 0);
      tick();
      a_if.start = 1'b0;
      chk("held_rebusy", 32'(a_if.busy), 1);
      chk("held_rein", 32'(a_if.dut_in), 0);
      chk("held_reerr", 32'(a_if.err_count), 0);
      chk("held_refv", 32'(a_if.fail_valid), 0);
      chk("held_repass", 32'(a_if.pass), 0);
      repeat (23) tick();
      chk("held2_nodone", 32'(a_if.done), 0);
      tick();
      chk("held2_done", 32'(a_if.done), 1);
      chk("held2_pass", 32'(a_if.pass), 1);
      tick();

      // reset mid-run while vector 4 is applied, with errors already counted
      mode_a     = M_INV;
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      repeat (12) tick();
      chk("mid_in4", 32'(a_if.dut_in), 4);
      chk("mid_err_live", 32'(a_if.err_count), 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle_zero("midrst");
      tick();
      chk("midrst_stay", 32'(a_if.busy), 0);

      mode_a = M_GOLD;
      run_a("after_rst", 0, 0, 0, 1, 1'b0);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Sequential stimulus/response engine for small combinational functions of up to N_IN inputs, such as a 3-input `fxyz`-style function. It drives every input vector from 0 to 2^N_IN−1 onto the function's inputs and waits a fixed settle time. It then samples the single-bit function output and compares it against a golden truth table given as a parameter. It reports the mismatch count, the first failing vector and a pass flag, replacing hand-written `$display` truth-table benches with a checkable hardware block.

## Interface
- N_IN, 3, number of function inputs; 1..6.
- EXPECTED, 8'hE2, golden truth table, width 2^N_IN; bit i is the expected output for input vector i. The default encodes s = (~y & z) | (x & y) with index {x,y,z}.
- SETTLE, 2, cycles each vector is held before sampling; ≥1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to begin a run; honoured only in IDLE.
- dut_in  output  N_IN  vector driven to the function under test; bit N_IN−1 is x.
- dut_out  input  1  function output being checked.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  high iff the last completed run had zero mismatches; held until the next accepted start.
- err_count  output  N_IN+1  mismatches in the current or last run; saturation impossible (max 2^N_IN).
- fail_valid  output  1  at least one mismatch captured.
- first_fail  output  N_IN  lowest-index failing vector; valid when fail_valid.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: busy=0. start=1 → vector←0, timer←0, err_count←0, fail_valid←0, first_fail←0, pass←0 → SETTLE.
- SETTLE: dut_in=vector. timer increments each cycle; when timer==SETTLE−1 → CHECK, timer←0.
- CHECK: dut_out is compared to EXPECTED[vector].
  - On mismatch: err_count+1; if fail_valid==0, set first_fail←vector and fail_valid←1.
  - If vector==2^N_IN−1 → DONE, with pass←(final err_count==0), including a mismatch in this cycle.
  - Otherwise vector+1 → SETTLE.
- DONE: done=1, busy=1 for one cycle → IDLE.
- dut_in holds its last value (2^N_IN−1) in DONE and IDLE until the next start resets it to 0.
- start is ignored in SETTLE, CHECK and DONE. No queuing: a start held high across DONE is re-accepted in the first IDLE cycle.
- The vector counter is N_IN bits. The end condition is compared explicitly and never relies on wrap-around.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, state=IDLE.
- rst wins over every other event, including mid-run and in the same cycle as start. No partial results survive reset.
- If start is sampled high at edge k:
  - dut_in=0 and busy=1 from edge k.
  - Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 in CHECK.
  - dut_out is sampled at the edge ending CHECK, i.e. SETTLE+1 edges after the vector was applied.
- DONE is entered at edge k+2^N_IN·(SETTLE+1); done is high for exactly that cycle. With defaults this is edge k+24.
- pass, err_count, fail_valid and first_fail are final by the cycle done is high.
- err_count and first_fail update at CHECK edges during the run and are observable live.
- Start-to-restart minimum spacing is 2^N_IN·(SETTLE+1)+2 edges. Defaults: 26.

## Test plan
- Reset: hold rst 3 cycles with start=1 → all outputs 0, state IDLE, no run starts during reset.
- Golden DUT, (~y&z)|(x&y), defaults, start pulse at edge k → dut_in steps 0..7 with each value held 3 cycles; done at k+24 only; pass=1, err_count=0, fail_valid=0.
- Stuck-at-0 DUT → err_count=4, first_fail=1, fail_valid=1, pass=0.
- Inverted DUT → err_count=8, first_fail=0, pass=0.
- Also test SETTLE=1 with a golden DUT → done at k+16.
- start held high throughout → busy never drops for more than one cycle between runs; second run restarts at dut_in=0 with counters cleared.
- Start re-pulses mid-run → ignored.
- rst asserted while dut_in=4 → next cycle all outputs 0 and IDLE. A subsequent start with a golden DUT → pass=1, err_count=0.
